// File: rtl/regfile_pkg.sv
// Shared sizing constants and scan FSM state encoding for the register-file scan controller.
package regfile_pkg;
    localparam int REG_COUNT = 32;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_HOLD,
        ST_FIN
    } scan_state_e;
endpackage

// File: rtl/regfile_scan_ctrl.sv
// Register-file scan controller: borrows the regfile ports from the processor to stream
// every register out over a valid/ready scan interface, stalling processor writeback meanwhile.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | processor owns the regfile ports; wait for start
// ST_READ | drive index on read port A, capture data into scan_*
// ST_HOLD | scan beat valid; wait for scan_ready, then advance or finish
// ST_FIN  | one-cycle done pulse, then release ports back to processor
module regfile_scan_ctrl
    import regfile_pkg::*;
#(
    parameter int REG_COUNT = regfile_pkg::REG_COUNT,
    parameter int DATA_W    = regfile_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              p_writeEnable,
    input  logic [ADDR_W-1:0] p_writeReg,
    input  logic [DATA_W-1:0] p_data_writeReg,
    input  logic [ADDR_W-1:0] p_readRegA,
    input  logic [DATA_W-1:0] rf_data_readRegA,
    output logic              rf_writeEnable,
    output logic [ADDR_W-1:0] rf_writeReg,
    output logic [DATA_W-1:0] rf_data_writeReg,
    output logic [ADDR_W-1:0] rf_readRegA,
    output logic              p_stall,
    output logic              scan_valid,
    input  logic              scan_ready,
    output logic [ADDR_W-1:0] scan_reg,
    output logic [DATA_W-1:0] scan_data,
    output logic              busy,
    output logic              done
);

    scan_state_e       state, state_nxt;
    logic [ADDR_W-1:0] idx;
    logic              last;

    assign last = (idx == ADDR_W'(REG_COUNT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Index and captured beat; the index saturates at the last register instead of wrapping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx        <= '0;
            scan_valid <= 1'b0;
            scan_reg   <= '0;
            scan_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) idx <= '0;
                end
                ST_READ: begin
                    scan_valid <= 1'b1;
                    scan_reg   <= idx;
                    scan_data  <= rf_data_readRegA;
                end
                ST_HOLD: begin
                    if (scan_ready) begin
                        scan_valid <= 1'b0;
                        if (!last) idx <= idx + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt        = state;
        busy             = 1'b1;
        p_stall          = 1'b1;
        done             = 1'b0;
        rf_writeEnable   = 1'b0;
        rf_writeReg      = p_writeReg;
        rf_data_writeReg = p_data_writeReg;
        rf_readRegA      = idx;
        case (state)
            ST_IDLE: begin
                busy           = 1'b0;
                p_stall        = 1'b0;
                rf_writeEnable = p_writeEnable;
                rf_readRegA    = p_readRegA;
                if (start) state_nxt = ST_READ;
            end
            ST_READ: state_nxt = ST_HOLD;
            ST_HOLD: begin
                if (scan_ready) state_nxt = last ? ST_FIN : ST_READ;
            end
            ST_FIN: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_regfile_scan_ctrl.sv
// Directed bench for regfile_scan_ctrl with a behavioural register file attached to the rf_* ports.
module tb_regfile_scan_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        p_writeEnable;
    logic [4:0]  p_writeReg;
    logic [31:0] p_data_writeReg;
    logic [4:0]  p_readRegA;
    logic [31:0] rf_data_readRegA;
    logic        rf_writeEnable;
    logic [4:0]  rf_writeReg;
    logic [31:0] rf_data_writeReg;
    logic [4:0]  rf_readRegA;
    logic        p_stall;
    logic        scan_valid;
    logic        scan_ready;
    logic [4:0]  scan_reg;
    logic [31:0] scan_data;
    logic        busy;
    logic        done;

    logic [31:0] mem     [32];
    logic [31:0] exp_mem [32];

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    regfile_scan_ctrl dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .p_writeEnable    (p_writeEnable),
        .p_writeReg       (p_writeReg),
        .p_data_writeReg  (p_data_writeReg),
        .p_readRegA       (p_readRegA),
        .rf_data_readRegA (rf_data_readRegA),
        .rf_writeEnable   (rf_writeEnable),
        .rf_writeReg      (rf_writeReg),
        .rf_data_writeReg (rf_data_writeReg),
        .rf_readRegA      (rf_readRegA),
        .p_stall          (p_stall),
        .scan_valid       (scan_valid),
        .scan_ready       (scan_ready),
        .scan_reg         (scan_reg),
        .scan_data        (scan_data),
        .busy             (busy),
        .done             (done)
    );

    always @(posedge clock) begin
        if (rf_writeEnable) mem[rf_writeReg] <= rf_data_writeReg;
    end
    assign rf_data_readRegA = mem[rf_readRegA];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Full scan from start to done with optional ready stall, mid-scan start pulse and stalled write to r7.
    task automatic run_scan(input int hold_beat, input int restart_beat, input int wr_beat);
        int beats    = 0;
        int dones    = 0;
        int cyc      = 0;
        int done_cyc = -1;
        bit held     = 1'b0;
        bit wr_pend  = 1'b0;
        logic [31:0] hd;
        scan_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
        while (cyc < 400 && done_cyc < 0) begin
            if (scan_valid) begin
                if (beats == hold_beat && !held) begin
                    scan_ready = 1'b0;
                    hd = scan_data;
                    repeat (5) begin
                        step();
                        cyc++;
                        check_val("hold_valid", 32'(scan_valid), 32'd1);
                        check_val("hold_reg", 32'(scan_reg), 32'(hold_beat));
                        check_val("hold_data", scan_data, hd);
                    end
                    held = 1'b1;
                    scan_ready = 1'b1;
                end
                check_val("beat_reg", 32'(scan_reg), 32'(beats));
                check_val("beat_data", scan_data, exp_mem[beats & 31]);
                if (beats == restart_beat) start = 1'b1;
                if (beats == wr_beat) begin
                    p_writeEnable = 1'b1;
                    p_writeReg = 5'd7;
                    p_data_writeReg = 32'h77;
                    #1;
                    check_val("wr_stall", 32'(p_stall), 32'd1);
                    check_val("wr_blocked", 32'(rf_writeEnable), 32'd0);
                    wr_pend = 1'b1;
                end
                beats++;
            end
            step();
            cyc++;
            start = 1'b0;
            if (done) begin
                dones++;
                done_cyc = cyc;
                check_val("busy_at_done", 32'(busy), 32'd1);
            end
        end
        check_val("beat_count", 32'(beats), 32'd32);
        check_val("done_count", 32'(dones), 32'd1);
        check_val("done_cycle", 32'(done_cyc), 32'(held ? 70 : 65));
        step();
        check_val("done_pulse_end", 32'(done), 32'd0);
        check_val("busy_after_done", 32'(busy), 32'd0);
        if (wr_pend) begin
            check_val("wr_release_stall", 32'(p_stall), 32'd0);
            check_val("wr_release_we", 32'(rf_writeEnable), 32'd1);
            step();
            p_writeEnable = 1'b0;
            exp_mem[7] = 32'h77;
            check_val("wr_landed", mem[7], 32'h77);
        end
    endtask

    initial begin
        int n;
        int dones;
        reset = 1'b1;
        start = 1'b0;
        p_writeEnable = 1'b0;
        p_writeReg = '0;
        p_data_writeReg = '0;
        p_readRegA = '0;
        scan_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            mem[i] = 32'h1000_0000 + 32'(i);
            exp_mem[i] = 32'h1000_0000 + 32'(i);
        end
        #1;
        check_val("rst_valid", 32'(scan_valid), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_stall", 32'(p_stall), 32'd0);
        check_val("rst_reg", 32'(scan_reg), 32'd0);
        check_val("rst_data", scan_data, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        p_writeEnable = 1'b1;
        p_writeReg = 5'd3;
        p_data_writeReg = 32'hAB;
        p_readRegA = 5'd5;
        #1;
        check_val("idle_we", 32'(rf_writeEnable), 32'd1);
        check_val("idle_wreg", 32'(rf_writeReg), 32'd3);
        check_val("idle_wdata", rf_data_writeReg, 32'hAB);
        check_val("idle_rreg", 32'(rf_readRegA), 32'd5);
        check_val("idle_stall", 32'(p_stall), 32'd0);
        step();
        exp_mem[3] = 32'hAB;
        p_writeReg = 5'd1;
        p_data_writeReg = 32'd65535;
        step();
        exp_mem[1] = 32'd65535;
        p_writeReg = 5'd31;
        p_data_writeReg = 32'hDEADBEEF;
        step();
        exp_mem[31] = 32'hDEADBEEF;
        p_writeEnable = 1'b0;
        check_val("preload_r3", mem[3], 32'hAB);

        run_scan(-1, -1, 5);
        run_scan(4, 10, -1);

        scan_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (n < 100 && !(scan_valid && scan_reg == 5'd17)) begin
            step();
            n++;
        end
        check_val("reach_idx17", 32'(scan_reg), 32'd17);
        #2;
        reset = 1'b1;
        p_writeEnable = 1'b1;
        p_writeReg = 5'd9;
        p_data_writeReg = 32'h99;
        #1;
        check_val("abort_valid", 32'(scan_valid), 32'd0);
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_done", 32'(done), 32'd0);
        check_val("abort_reg", 32'(scan_reg), 32'd0);
        repeat (2) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check_val("post_rst_stall", 32'(p_stall), 32'd0);
        check_val("post_rst_we", 32'(rf_writeEnable), 32'd1);
        check_val("post_rst_wreg", 32'(rf_writeReg), 32'd9);
        dones = 0;
        step();
        p_writeEnable = 1'b0;
        exp_mem[9] = 32'h99;
        repeat (4) begin
            if (done) dones++;
            step();
        end
        check_val("abort_no_done", 32'(dones), 32'd0);
        check_val("post_rst_write", mem[9], 32'h99);

        run_scan(-1, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_scan_ctrl.md
REGFILE_SCAN_CTRL -- requirements
Module: regfile_scan_ctrl

Interface
REQ-001 Parameter REG_COUNT, default 32: number of registers scanned.
REQ-002 Parameter DATA_W, default 32: register data width.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset; the ports SHALL be named clock and reset.
REQ-004 clock  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 start  in  1  single-cycle request to begin a full register scan.
REQ-007 p_writeEnable  in  1  processor writeback enable.
REQ-008 p_writeReg  in  5  processor writeback register index.
REQ-009 p_data_writeReg  in  DATA_W  processor writeback data.
REQ-010 p_readRegA  in  5  processor read-port-A index.
REQ-011 rf_data_readRegA  in  DATA_W  regfile port-A read data, combinational from rf_readRegA.
REQ-012 rf_writeEnable  out  1  muxed regfile write enable.
REQ-013 rf_writeReg  out  5  muxed regfile write index.
REQ-014 rf_data_writeReg  out  DATA_W  muxed regfile write data.
REQ-015 rf_readRegA  out  5  muxed regfile read-port-A index.
REQ-016 p_stall  out  1  processor SHALL hold its writeback while high.
REQ-017 scan_valid  out  1  scan_reg/scan_data hold a captured register.
REQ-018 scan_ready  in  1  consumer accepts the current scan beat.
REQ-019 scan_reg  out  5  index of the captured register.
REQ-020 scan_data  out  DATA_W  captured register value.
REQ-021 busy  out  1  high in every non-IDLE state.
REQ-022 done  out  1  one-cycle pulse after the last beat is accepted.

Function
REQ-023 The FSM SHALL have states IDLE, READ, HOLD and FIN.
REQ-024 In IDLE, rf_* SHALL pass the p_* inputs through, and p_stall SHALL be 0.
REQ-025 In IDLE, start=1 SHALL clear the index to 0 and go to READ; the processor write in that same cycle SHALL be passed through.
REQ-026 In READ, rf_readRegA SHALL equal the index; rf_data_readRegA SHALL be registered into scan_data and the index into scan_reg; scan_valid SHALL be set; the next state SHALL be HOLD. Latency from address to valid is one cycle.
REQ-027 In HOLD, scan_valid, scan_reg and scan_data SHALL stay stable until scan_ready=1.
REQ-028 On acceptance in HOLD: if index = REG_COUNT-1, go to FIN; otherwise increment the index and go to READ. scan_valid SHALL drop in the cycle after acceptance.
REQ-029 In FIN, done SHALL be 1 for exactly one cycle; the next state SHALL be IDLE.
REQ-030 In all non-IDLE states, p_stall SHALL be 1 and rf_writeEnable SHALL be 0; processor writes are never lost, only stalled.
REQ-031 start SHALL be ignored in any non-IDLE state.
REQ-032 Register 0 SHALL be scanned like any other register; the block performs no special casing.
REQ-033 The index SHALL be 5 bits and SHALL never wrap past REG_COUNT-1.
REQ-034 scan_ready held high continuously SHALL yield one beat every 2 cycles.

Reset
REQ-035 Reset SHALL force state IDLE, index 0, scan_valid 0, scan_reg 0, scan_data 0, done 0, busy 0 and p_stall 0, effective immediately and asynchronously.
REQ-036 Reset asserted mid-scan SHALL abort the scan without producing a done pulse; the processor pass-through SHALL resume on the first cycle after reset deasserts.

Structure
REQ-037 The shared package regfile_pkg SHALL hold REG_COUNT, DATA_W, ADDR_W=5 and the FSM state typedef.
REQ-038 The block SHALL be a single module with no sub-module; the muxing SHALL be combinational on state.

Verification
REQ-039 Reset, then IDLE with p_writeEnable=1, p_writeReg=3, data 0xAB -> rf_writeEnable=1, rf_writeReg=3, rf_data_writeReg=0xAB, p_stall=0.
REQ-040 Preload r1=65535, r31=0xDEADBEEF; pulse start with scan_ready tied to 1 -> 32 beats over 64 cycles, in order 0..31; beat 1 data=65535, beat 31 data=0xDEADBEEF; done pulses once; busy falls the cycle after done.
REQ-041 Hold scan_ready=0 for 5 cycles on beat 4 -> scan_reg=4 and scan_data held stable for all 5 cycles; next beat is 5.
REQ-042 Pulse start again during the scan at index 10 -> the scan is neither restarted nor duplicated, and a total of 32 beats is produced.
REQ-043 Processor attempts a write to r7 during the scan -> p_stall=1 and rf_writeEnable=0; after done the held write reaches r7.
REQ-044 Assert reset at index 17 -> scan_valid=0, busy=0 and no done pulse; a new start scans from index 0.
